// File: rtl/clk_div_monitor.sv
// Measures the period of a divided clock sampled as data in the fast clock domain and
// reports lock / sticky fault status against an expected ratio.
module clk_div_monitor #(
    parameter int unsigned EXPECTED   = 8,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned CW         = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          div_i,
    input  logic          clr_i,
    output logic          edge_o,
    output logic          valid_o,
    output logic [CW-1:0] period_o,
    output logic          locked_o,
    output logic          fault_o
);

    typedef enum logic [1:0] {StIdle, StMeasure, StLocked, StFault} state_e;

    localparam logic [CW-1:0] GoodLo     = CW'(EXPECTED - TOL);
    localparam logic [CW-1:0] GoodHi     = CW'(EXPECTED + TOL);
    localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);
    localparam logic [CW-1:0] CntOne     = CW'(1);
    localparam logic [3:0]    LockTarget = 4'(LOCK_COUNT);

    logic          s1, s2, s3;
    logic [CW-1:0] cnt_q;
    logic [3:0]    good_cnt_q, good_cnt_d;
    state_e        state_q, state_d;
    logic          e, good, timeout, cnt_max;

    assign e       = s2 & ~s3;
    assign cnt_max = (cnt_q == {CW{1'b1}});
    assign good    = (cnt_q >= GoodLo) && (cnt_q <= GoodHi);
    assign timeout = (cnt_q >= TimeoutCnt) && !e;

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        if (clr_i) begin
            state_d    = StIdle;
            good_cnt_d = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (e) begin
                        state_d    = StMeasure;
                        good_cnt_d = 4'd0;
                    end else if (timeout) begin
                        state_d = StFault;
                    end
                end
                StMeasure: begin
                    if (e && good) begin
                        if (good_cnt_q + 4'd1 == LockTarget) begin
                            state_d    = StLocked;
                            good_cnt_d = 4'd0;
                        end else begin
                            good_cnt_d = good_cnt_q + 4'd1;
                        end
                    end else if (e) begin
                        good_cnt_d = 4'd0;
                    end else if (timeout) begin
                        state_d = StFault;
                    end
                end
                StLocked: begin
                    if ((e && !good) || timeout) begin
                        state_d = StFault;
                    end
                end
                StFault: state_d = StFault;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt_q      <= '0;
            good_cnt_q <= 4'd0;
            state_q    <= StIdle;
            edge_o     <= 1'b0;
            valid_o    <= 1'b0;
            period_o   <= '0;
            locked_o   <= 1'b0;
            fault_o    <= 1'b0;
        end else begin
            s1         <= div_i;
            s2         <= s1;
            s3         <= s2;
            edge_o     <= e;
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            // Status flags mirror the next state so they line up with state_q.
            locked_o   <= (state_d == StLocked);
            fault_o    <= (state_d == StFault);
            if (clr_i) begin
                cnt_q   <= '0;
                valid_o <= 1'b0;
            end else begin
                if (e) begin
                    cnt_q <= CntOne;
                end else if (!cnt_max) begin
                    cnt_q <= cnt_q + CntOne;
                end
                valid_o <= e && (state_q != StIdle);
                if (e && (state_q != StIdle)) begin
                    period_o <= cnt_q;
                end
            end
        end
    end

endmodule
